// File: rtl/dsp_adc_frame_gen.sv
// ADC pin-level frame emulator: framed bursts with selectable pattern, overflow
// injection and abort, driving ADC_OE_n / ADC_OF / ADC_DATA of the capture path.
module dsp_adc_frame_gen #(
    parameter int FRAME_LEN = 64,
    parameter int GAP_LEN   = 16
) (
    input  logic        ADC_CLK,
    input  logic        i_rstn,
    input  logic        i_enable,
    input  logic        i_abort,
    input  logic [1:0]  i_mode,
    input  logic [11:0] i_const,
    input  logic        i_of_inject,
    input  logic [11:0] i_of_index,
    output logic        o_adc_oe_n,
    output logic        o_adc_of,
    output logic [11:0] o_adc_data,
    output logic [15:0] o_frame_cnt,
    output logic [7:0]  o_abort_cnt,
    output logic        o_busy
);

    localparam logic [11:0] LAST_IDX  = 12'(FRAME_LEN - 1);
    localparam logic [11:0] LAST_GAP  = 12'(GAP_LEN - 1);
    localparam logic [11:0] LFSR_SEED = 12'hACE;

    typedef enum logic [1:0] {IDLE, FRAME, GAP} state_t;

    state_t      state_q;
    logic [11:0] idx_q;
    logic [11:0] gap_q;
    logic [1:0]  mode_q;
    logic [11:0] const_q;
    logic        inj_q;
    logic [11:0] of_idx_q;
    logic [11:0] lfsr_q;
    logic        abort_hit_q;
    logic        oe_n_q;
    logic        of_q;
    logic [11:0] data_q;
    logic [15:0] frame_cnt_q;
    logic [7:0]  abort_cnt_q;
    logic        busy_q;

    logic [11:0] sample_d;
    logic [11:0] lfsr_d;

    // x^12+x^6+x^4+x+1, shifting toward the MSB
    assign lfsr_d = {lfsr_q[10:0], lfsr_q[11] ^ lfsr_q[5] ^ lfsr_q[3] ^ lfsr_q[0]};

    always_comb begin
        sample_d = idx_q;
        case (mode_q)
            2'd0:    sample_d = idx_q;
            2'd1:    sample_d = const_q;
            2'd2:    sample_d = lfsr_q;
            default: sample_d = idx_q[0] ? 12'h7FF : 12'h800;
        endcase
    end

    // The FSM state leads the pins by one cycle; pins are registered from state_q.
    always_ff @(posedge ADC_CLK) begin
        if (!i_rstn) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            gap_q       <= '0;
            mode_q      <= '0;
            const_q     <= '0;
            inj_q       <= 1'b0;
            of_idx_q    <= '0;
            lfsr_q      <= LFSR_SEED;
            abort_hit_q <= 1'b0;
            oe_n_q      <= 1'b1;
            of_q        <= 1'b0;
            data_q      <= '0;
            frame_cnt_q <= '0;
            abort_cnt_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            abort_hit_q <= 1'b0;
            if (abort_hit_q && abort_cnt_q != 8'hFF)
                abort_cnt_q <= abort_cnt_q + 8'd1;

            case (state_q)
                IDLE: begin
                    oe_n_q <= 1'b1;
                    of_q   <= 1'b0;
                    busy_q <= i_enable;
                    if (i_enable) begin
                        state_q  <= FRAME;
                        idx_q    <= '0;
                        mode_q   <= i_mode;
                        const_q  <= i_const;
                        inj_q    <= i_of_inject;
                        of_idx_q <= i_of_index;
                    end
                end
                FRAME: begin
                    oe_n_q <= 1'b0;
                    of_q   <= inj_q && (idx_q == of_idx_q);
                    data_q <= sample_d;
                    lfsr_q <= lfsr_d;
                    busy_q <= 1'b1;
                    // Abort takes priority over completion on the last sample
                    if (i_abort) begin
                        state_q     <= GAP;
                        gap_q       <= '0;
                        abort_hit_q <= 1'b1;
                    end else if (idx_q == LAST_IDX) begin
                        state_q     <= GAP;
                        gap_q       <= '0;
                        frame_cnt_q <= frame_cnt_q + 16'd1;
                    end else begin
                        idx_q <= idx_q + 12'd1;
                    end
                end
                GAP: begin
                    oe_n_q <= 1'b1;
                    of_q   <= 1'b0;
                    if (gap_q == LAST_GAP) begin
                        busy_q <= i_enable;
                        if (i_enable) begin
                            state_q  <= FRAME;
                            idx_q    <= '0;
                            mode_q   <= i_mode;
                            const_q  <= i_const;
                            inj_q    <= i_of_inject;
                            of_idx_q <= i_of_index;
                        end else begin
                            state_q <= IDLE;
                        end
                    end else begin
                        gap_q  <= gap_q + 12'd1;
                        busy_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    oe_n_q  <= 1'b1;
                    of_q    <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_adc_oe_n  = oe_n_q;
    assign o_adc_of    = of_q;
    assign o_adc_data  = data_q;
    assign o_frame_cnt = frame_cnt_q;
    assign o_abort_cnt = abort_cnt_q;
    assign o_busy      = busy_q;

endmodule

// File: tb/tb_dsp_adc_frame_gen.sv
// Directed and randomized frames for dsp_adc_frame_gen, checked against a
// frame-level reference of the expected pin activity.
module tb_dsp_adc_frame_gen;

    localparam int L = 8;
    localparam int G = 2;

    logic        ADC_CLK = 1'b0;
    logic        i_rstn = 1'b1;
    logic        i_enable = 1'b0;
    logic        i_abort = 1'b0;
    logic [1:0]  i_mode = 2'd0;
    logic [11:0] i_const = 12'd0;
    logic        i_of_inject = 1'b0;
    logic [11:0] i_of_index = 12'd0;
    logic        o_adc_oe_n;
    logic        o_adc_of;
    logic [11:0] o_adc_data;
    logic [15:0] o_frame_cnt;
    logic [7:0]  o_abort_cnt;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state
    logic [11:0] m_lfsr = 12'hACE;
    int          m_frames = 0;
    int          m_aborts = 0;
    logic [1:0]  m_mode = 2'd0;
    logic [11:0] m_const = 12'd0;
    logic        m_inj = 1'b0;
    logic [11:0] m_ofidx = 12'd0;

    dsp_adc_frame_gen #(.FRAME_LEN(L), .GAP_LEN(G)) dut (
        .ADC_CLK    (ADC_CLK),
        .i_rstn     (i_rstn),
        .i_enable   (i_enable),
        .i_abort    (i_abort),
        .i_mode     (i_mode),
        .i_const    (i_const),
        .i_of_inject(i_of_inject),
        .i_of_index (i_of_index),
        .o_adc_oe_n (o_adc_oe_n),
        .o_adc_of   (o_adc_of),
        .o_adc_data (o_adc_data),
        .o_frame_cnt(o_frame_cnt),
        .o_abort_cnt(o_abort_cnt),
        .o_busy     (o_busy)
    );

    always #5 ADC_CLK = ~ADC_CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Polynomial x^12+x^6+x^4+x+1: feedback is the parity of the tapped exponents.
    function automatic logic [11:0] lfsr_step(input logic [11:0] s);
        int  taps [4] = '{12, 6, 4, 1};
        logic fb = 1'b0;
        foreach (taps[t]) fb ^= s[taps[t]-1];
        return {s[10:0], fb};
    endfunction

    function automatic logic [11:0] exp_sample(input int i);
        case (m_mode)
            2'd0:    return 12'(i);
            2'd1:    return m_const;
            2'd2:    return m_lfsr;
            default: return (i % 2 == 0) ? 12'h800 : 12'h7FF;
        endcase
    endfunction

    task automatic do_reset();
        i_rstn = 1'b0;
        @(posedge ADC_CLK); #1;
        i_rstn = 1'b1;
        m_lfsr = 12'hACE; m_frames = 0; m_aborts = 0;
        chk("rst_oe_n", o_adc_oe_n, 1);
        chk("rst_of", o_adc_of, 0);
        chk("rst_data", o_adc_data, 0);
        chk("rst_frame_cnt", o_frame_cnt, 0);
        chk("rst_abort_cnt", o_abort_cnt, 0);
        chk("rst_busy", o_busy, 0);
        $display("reset applied");
    endtask

    task automatic set_cfg(input logic [1:0] mode, input logic [11:0] cval,
                           input logic inj, input logic [11:0] ofi);
        i_mode = mode; i_const = cval; i_of_inject = inj; i_of_index = ofi;
        m_mode = mode; m_const = cval; m_inj = inj; m_ofidx = ofi;
    endtask

    task automatic start_frame(input bit cont);
        i_enable = 1'b1;
        @(posedge ADC_CLK); #1;
        if (!cont) i_enable = 1'b0;
    endtask

    // abort_at: sample index whose FSM cycle sees i_abort; stop_at: return early
    // after that sample; drop_at: release i_enable after that sample.
    task automatic do_frame(input int abort_at, input int stop_at, input int drop_at);
        bit aborted = 0;
        int n = 0;
        for (int i = 0; i < L; i++) begin
            if (i == abort_at) i_abort = 1'b1;
            @(posedge ADC_CLK); #1;
            i_abort = 1'b0;
            chk("frame_oe_n", o_adc_oe_n, 0);
            chk("frame_data", o_adc_data, exp_sample(i));
            chk("frame_of", o_adc_of, (m_inj && i == int'(m_ofidx)) ? 1 : 0);
            m_lfsr = lfsr_step(m_lfsr);
            n++;
            if (i == drop_at) i_enable = 1'b0;
            if (i == stop_at) begin
                $display("frame mode=%0d stopped after %0d samples", m_mode, n);
                return;
            end
            if (i == abort_at) begin
                aborted = 1;
                break;
            end
        end
        if (aborted) begin
            m_aborts = (m_aborts < 255) ? m_aborts + 1 : 255;
        end else begin
            m_frames = (m_frames + 1) % 65536;
            chk("frame_cnt_at_last", o_frame_cnt, m_frames);
        end
        $display("frame mode=%0d const=%h inj=%0d ofidx=%0d samples=%0d aborted=%0d",
                 m_mode, m_const, m_inj, m_ofidx, n, aborted);
    endtask

    task automatic do_gap(input bit abort_probe);
        for (int j = 0; j < G; j++) begin
            if (abort_probe && j == 0) i_abort = 1'b1;
            @(posedge ADC_CLK); #1;
            i_abort = 1'b0;
            chk("gap_oe_n", o_adc_oe_n, 1);
            chk("gap_of", o_adc_of, 0);
            chk("gap_frame_cnt", o_frame_cnt, m_frames);
            chk("gap_abort_cnt", o_abort_cnt, m_aborts);
            if (j < G - 1) chk("gap_busy", o_busy, 1);
        end
        $display("gap of %0d cycles", G);
    endtask

    task automatic idle_check();
        @(posedge ADC_CLK); #1;
        chk("idle_oe_n", o_adc_oe_n, 1);
        chk("idle_busy", o_busy, 0);
        chk("idle_frame_cnt", o_frame_cnt, m_frames);
    endtask

    initial begin
        // reset state
        do_reset();

        // single ramp frame, abort pulse in the gap must be ignored
        set_cfg(2'd0, 12'h000, 1'b0, 12'd0);
        start_frame(0);
        do_frame(-1, -1, -1);
        do_gap(1);
        idle_check();

        // continuous constant frames; input changes after latching must not leak in
        do_reset();
        set_cfg(2'd1, 12'h5A5, 1'b0, 12'd0);
        start_frame(1);
        i_const = 12'h123; i_mode = 2'd3;
        do_frame(-1, -1, -1);
        i_const = 12'h5A5; i_mode = 2'd1;
        do_gap(0);
        do_frame(-1, -1, -1);
        do_gap(0);
        do_frame(-1, -1, 3);
        do_gap(0);
        idle_check();
        chk("three_frames", o_frame_cnt, 3);

        // overflow injection inside and beyond the frame
        set_cfg(2'd0, 12'h000, 1'b1, 12'd5);
        start_frame(0);
        do_frame(-1, -1, -1);
        do_gap(0);
        idle_check();
        set_cfg(2'd0, 12'h000, 1'b1, 12'd9);
        start_frame(0);
        do_frame(-1, -1, -1);
        do_gap(0);
        idle_check();

        // aborts mid-frame and on the last sample
        set_cfg(2'd3, 12'h000, 1'b0, 12'd0);
        start_frame(0);
        do_frame(3, -1, -1);
        do_gap(0);
        idle_check();
        set_cfg(2'd0, 12'h000, 1'b0, 12'd0);
        start_frame(0);
        do_frame(7, -1, -1);
        do_gap(0);
        idle_check();

        // LFSR from seed, continuing across the gap
        do_reset();
        set_cfg(2'd2, 12'h000, 1'b0, 12'd0);
        start_frame(1);
        do_frame(-1, -1, -1);
        do_gap(0);
        do_frame(-1, -1, 2);
        do_gap(0);
        idle_check();

        // reset in the middle of a frame, then restart in LFSR mode
        set_cfg(2'd0, 12'h000, 1'b0, 12'd0);
        start_frame(0);
        do_frame(-1, 4, -1);
        do_reset();
        set_cfg(2'd2, 12'h000, 1'b0, 12'd0);
        start_frame(0);
        do_frame(-1, -1, -1);
        do_gap(0);
        idle_check();

        // randomized frames
        for (int r = 0; r < 8; r++) begin
            int ab;
            set_cfg(2'($urandom_range(0, 3)), 12'($urandom), 1'($urandom_range(0, 1)),
                    12'($urandom_range(0, 9)));
            ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, L - 1)) : -1;
            start_frame(0);
            do_frame(ab, -1, -1);
            do_gap(0);
            idle_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dsp_adc_frame_gen.md
# dsp_adc_frame_gen

ADC frame emulator for bring-up and verification of the DSP capture path. It runs in the ADC_CLK domain and drives the ADC pin-level interface (ADC_OE_n, ADC_OF, ADC_DATA) of the receiver directly upstream, in place of the physical ADC. It produces framed bursts with configurable length, gap and data pattern, plus overflow injection and mid-frame abort, so the receiver's SoF and overflow handling can be exercised deterministically.

## Interface
- FRAME_LEN, 64, samples per frame; legal range 1..4095.
- GAP_LEN, 16, idle cycles (o_adc_oe_n high) between frames; legal range 1..4095. 0 is illegal because the SoF edge must stay detectable.
- ADC_CLK  in  1  ADC clock; all logic on the rising edge.
- i_rstn  in  1  reset, synchronous, active-low.
- i_enable  in  1  level; frames are generated while high.
- i_abort  in  1  single-cycle pulse; truncates the current frame.
- i_mode  in  2  pattern select: 0 ramp, 1 constant, 2 LFSR, 3 full-scale toggle.
- i_const  in  12  value used in constant mode.
- i_of_inject  in  1  enables overflow injection for the next frame.
- i_of_index  in  12  sample index at which ADC_OF is asserted.
- o_adc_oe_n  out  1  active-low frame valid, connects to ADC_OE_n.
- o_adc_of  out  1  overflow flag, connects to ADC_OF.
- o_adc_data  out  12  sample data, 2's complement, connects to ADC_DATA.
- o_frame_cnt  out  16  count of completed (non-aborted) frames; wraps.
- o_abort_cnt  out  8  count of aborted frames; saturates at 255.
- o_busy  out  1  high whenever the state is not IDLE.

## Operation
- FSM has three states: IDLE, FRAME and GAP.
- IDLE
  - Outputs: o_adc_oe_n=1, o_adc_of=0, o_adc_data holds its last value.
  - i_enable=1 → FRAME. i_mode, i_const, i_of_inject and i_of_index are latched on this transition.
- FRAME
  - Sample index idx counts 0..FRAME_LEN-1; o_adc_oe_n=0.
  - At idx=FRAME_LEN-1 → GAP, and o_frame_cnt increments.
  - i_enable falling mid-frame does not truncate; the frame completes.
- GAP
  - Gap counter runs 0..GAP_LEN-1; o_adc_oe_n=1, o_adc_of=0.
  - On the last gap cycle: i_enable=1 → FRAME (configuration latched again); otherwise → IDLE.
- Abort
  - i_abort=1 in FRAME → GAP. No o_frame_cnt increment; o_abort_cnt increments.
  - i_abort is ignored in IDLE and GAP.
  - If i_abort coincides with idx=FRAME_LEN-1, abort wins: the frame counts as aborted.
- Patterns (latched per frame, unaffected by input changes mid-frame)
  - Ramp: data = idx[11:0].
  - Constant: data = latched i_const.
  - LFSR: 12-bit Fibonacci LFSR, polynomial x^12+x^6+x^4+x+1. Seed 12'hACE on reset only. Advances once per FRAME cycle and holds otherwise, so the sequence is continuous across frames.
  - Toggle: 12'h800 at even idx, 12'h7FF at odd idx.
- Overflow
  - o_adc_of=1 only in the FRAME cycle where idx equals the latched i_of_index, and only if the latched i_of_inject=1.
  - If i_of_index ≥ FRAME_LEN, ADC_OF is never asserted.
- Reset (synchronous, overrides everything, including mid-frame)
  - State returns to IDLE.
  - Outputs: o_adc_oe_n=1, o_adc_of=0, o_adc_data=0, o_frame_cnt=0, o_abort_cnt=0, o_busy=0.
  - LFSR reloads the 12'hACE seed.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- i_enable sampled high in IDLE at edge N → o_adc_oe_n=0 with idx 0 data valid after edge N+1.
- A frame occupies exactly FRAME_LEN consecutive cycles of o_adc_oe_n=0; the gap occupies exactly GAP_LEN cycles of o_adc_oe_n=1.
- Continuous enable gives a period of FRAME_LEN+GAP_LEN cycles.
- i_abort sampled at edge N → o_adc_oe_n=1 after edge N+1, and o_abort_cnt updates at edge N+1.
- o_frame_cnt updates at the edge where the last sample's oe_n is driven.
- o_adc_of and o_adc_data change on the same edge as o_adc_oe_n (same-cycle alignment, as the receiver captures all three together).
- Counter widths: idx and gap counters are 12 bits. o_frame_cnt wraps 16'hFFFF→0.

## Test plan
- Ramp, FRAME_LEN=8, GAP_LEN=2, single i_enable pulse
  - o_adc_oe_n low for exactly 8 cycles, data 0..7.
  - Then 2 high cycles, then IDLE; o_frame_cnt=1, o_busy=0.
- Continuous enable, constant mode, i_const=12'h5A5
  - Period is 10 cycles; every frame sample is 12'h5A5.
  - o_frame_cnt=3 after 3 frames.
- Overflow injection: i_of_inject=1, i_of_index=5
  - o_adc_of high only at idx 5 of that frame.
  - i_of_index=9 with FRAME_LEN=8 → ADC_OF never asserted.
- Abort
  - i_abort at idx 3 → o_adc_oe_n high next cycle; o_abort_cnt=1, o_frame_cnt unchanged.
  - Abort at idx 7 (last sample) → counts as abort.
- LFSR mode
  - First sample after reset = 12'hACE; subsequent samples match the reference LFSR model.
  - Sequence continues without restart across the gap into the next frame.
- Reset mid-frame at idx 4
  - Next cycle: o_adc_oe_n=1, o_adc_data=0, both counters 0, o_busy=0.
  - Re-enable restarts at idx 0 with LFSR seed 12'hACE.
